audio_gain_ramp: RTL



---
 rtl/audio_pkg.sv | 23 ++
 rtl/gain_sat_mul.sv | 43 ++++
 rtl/audio_gain_ramp.sv | 133 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio gain ramp: FSM states, unity gain
// and two's-complement sample limits.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic logic [31:0] unity_gain(input int frac_w);
    return 32'd1 << frac_w;
  endfunction

  function automatic logic signed [63:0] sample_max(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sample_min(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/gain_sat_mul.sv
// Combinational signed-sample x unsigned-gain multiply, floor shift by the gain
// fraction, and saturation to the sample range with a clip flag.
module gain_sat_mul
  import audio_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int GAIN_W = 8,
  parameter int FRAC_W = 7
) (
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic        [GAIN_W-1:0] gain_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     clip_o
);

  localparam int P_W = DATA_W + GAIN_W + 1;
  localparam logic signed [P_W-1:0] Y_MAX = P_W'(sample_max(DATA_W));
  localparam logic signed [P_W-1:0] Y_MIN = P_W'(sample_min(DATA_W));

  logic signed [P_W-1:0] s_ext;
  logic signed [P_W-1:0] g_ext;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] shifted;

  // Gain is zero-extended so it always acts as a positive multiplier.
  assign s_ext   = {{(P_W-DATA_W){sample_i[DATA_W-1]}}, sample_i};
  assign g_ext   = $signed({{(P_W-GAIN_W){1'b0}}, gain_i});
  assign prod    = s_ext * g_ext;
  assign shifted = prod >>> FRAC_W;

  always_comb begin
    y_o    = shifted[DATA_W-1:0];
    clip_o = 1'b0;
    if (shifted > Y_MAX) begin
      y_o    = Y_MAX[DATA_W-1:0];
      clip_o = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_o    = Y_MIN[DATA_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/audio_gain_ramp.sv
// Multi-channel volume stage: gain ramps toward the dial target once per
// accepted frame, channels are scaled one per cycle through a shared multiplier.
module audio_gain_ramp
  import audio_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 8,
  parameter int FRAC_W    = 7,
  parameter int STEP      = 4,
  parameter int INIT_GAIN = 128
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [GAIN_W-1:0]        gain_target,
  input  logic                     mute,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_clip,
  output logic [GAIN_W-1:0]        gain_cur
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [GAIN_W-1:0] STEP_G  = GAIN_W'(STEP);
  localparam logic [GAIN_W-1:0] INIT_G  = GAIN_W'(INIT_GAIN);

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [GAIN_W-1:0]        gain_cur_q, gain_cur_d;
  logic [GAIN_W-1:0]        gain_use_q, gain_use_d;
  logic [GAIN_W-1:0]        tgt, gain_step;
  logic [NUM_CH*DATA_W-1:0] frame_q;
  logic [NUM_CH*DATA_W-1:0] out_data_q;
  logic                     clip_q;
  logic                     accept;
  logic signed [DATA_W-1:0] mul_s;
  logic signed [DATA_W-1:0] mul_y;
  logic                     mul_clip;

  assign accept = in_valid && (state_q == IDLE);
  assign tgt    = mute ? '0 : gain_target;

  // Bounded step toward the target; never overshoots it.
  always_comb begin
    gain_step = gain_cur_q;
    if (tgt > gain_cur_q) begin
      gain_step = ((tgt - gain_cur_q) <= STEP_G) ? tgt : gain_cur_q + STEP_G;
    end else if (tgt < gain_cur_q) begin
      gain_step = ((gain_cur_q - tgt) <= STEP_G) ? tgt : gain_cur_q - STEP_G;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    gain_cur_d = gain_cur_q;
    gain_use_d = gain_use_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = MUL;
          ch_d       = '0;
          gain_use_d = gain_cur_q;
          gain_cur_d = gain_step;
        end
      end
      MUL: begin
        if (ch_q == LAST_CH) state_d = OUT;
        else                 ch_d    = ch_q + CH_W'(1);
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      gain_cur_q <= INIT_G;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      gain_cur_q <= gain_cur_d;
    end
  end

  // Frame capture: stage boundary into the multiply pass.
  always_ff @(posedge CLOCK_50) begin
    gain_use_q <= gain_use_d;
    if (accept) frame_q <= in_data;
  end

  assign mul_s = frame_q[ch_q*DATA_W +: DATA_W];

  gain_sat_mul #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .sample_i (mul_s),
    .gain_i   (gain_use_q),
    .y_o      (mul_y),
    .clip_o   (mul_clip)
  );

  // Output register: stage boundary, filled one channel per MUL cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_data_q <= '0;
      clip_q     <= 1'b0;
    end else if (accept) begin
      clip_q <= 1'b0;
    end else if (state_q == MUL) begin
      out_data_q[ch_q*DATA_W +: DATA_W] <= mul_y;
      clip_q                            <= clip_q | mul_clip;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_clip  = clip_q;
  assign gain_cur  = gain_cur_q;

endmodule
